mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Responder side of the device memory-request interface used by the pipeline stages.
//  Two requesters share one port: device 0 is fetch (read-only), device 1 is decode (read/write, byte lanes).
//  Round-robin arbitration between them. Drives one synchronous single-port RAM (1-cycle read latency).
//  Returns read data on shared mem_do and a per-device one-cycle do_ack. Optional short bursts.
// PARAMETERS
//  AW         10  word-address width of device and RAM address
//  DW         32  data width
//  BURST_LEN  4   max beats per burst (>=1); address increments by 1 per beat
// PORTS
//  clk                  in   1    clock, all state on rising edge
//  reset                in   1    asynchronous, active-high
//  device_1_mem_addr    in   AW   dev0 (fetch) word address
//  device_1_mem_di      in   DW   dev0 write data; ignored, dev0 never writes
//  device_2_mem_addr    in   AW   dev1 (decode) word address
//  device_2_mem_di      in   DW   dev1 write data
//  device_2_bank_select in   4    dev1 byte-lane write enables; bit i = di[8i+7:8i]
//  devices_burst_en     in   2    per-device burst request
//  devices_mem_we       in   2    per-device write; bit 0 ignored
//  devices_mem_en       in   2    per-device request; held until that device's do_ack
//  devices_do_ack       out  2    one-cycle completion pulse; at most one bit set
//  mem_do               out  DW   read data; valid in the ack cycle of a read
//  ram_en               out  1    RAM access strobe
//  ram_we               out  1    RAM write strobe
//  ram_be               out  4    RAM byte enables (4'hF for reads)
//  ram_addr             out  AW   RAM word address
//  ram_di               out  DW   RAM write data
//  ram_do               in   DW   RAM read data; valid the cycle after ram_en
// BEHAVIOUR
//  Reset: FSM=IDLE, grant=0, last_grant=1, beat=0, mem_do=0.
//  Reset: do_ack=0, ram_en=ram_we=0, ram_be=0, ram_addr=0, ram_di=0.
//  Reset mid-access aborts the access. No ack is given.
//  Reset mid-access: a request still held after reset is re-served from scratch.
//  FSM IDLE->ISSUE->WAIT->ACK for reads; IDLE->ISSUE->ACK for writes.
//  IDLE: sample mem_en. If one bit is set, grant that device.
//  IDLE: if both bits are set, grant the device != last_grant (first tie after reset goes to dev0).
//  IDLE: latch addr, we (bit 0 forced 0), di, bank_select and burst_en of the winner. beat<=0. Go to ISSUE.
//  ISSUE: ram_en=1, ram_we=latched we, ram_be=we?bank_select:4'hF, ram_addr/ram_di from latches.
//  ISSUE: next state is WAIT for a read, ACK for a write.
//  WAIT: ram_en=0. mem_do<=ram_do at end of cycle.
//  ACK: devices_do_ack[grant]=1 for exactly one cycle. last_grant<=grant.
//  Latency: mem_en sampled high at edge k -> read do_ack high in cycle k+3, write do_ack in cycle k+2.
//  Burst: if latched burst_en && beat<BURST_LEN-1 && mem_en[grant] still high in ACK:
//    beat++, addr<=addr+1 mod 2^AW (wraps), go to ISSUE; grant is not re-arbitrated.
//  Burst ends when mem_en[grant] drops, beat reaches BURST_LEN-1, or burst_en is low; then go to IDLE.
//  Burst write data and bank_select are re-latched each beat from dev1 inputs in ACK.
//  Write with bank_select=0: ram_en pulses with be=0, no RAM change, still acked.
//  mem_do holds its last value between acks and is unchanged by writes.
//  Requests arriving during a busy access wait; no request is dropped.
//  mem_en low in IDLE: outputs stay idle.
// TESTING
//  1. dev0 read addr 0x005, RAM[5]=0xDEADBEEF -> ram_en cycle k+1; do_ack=2'b01 with mem_do=0xDEADBEEF in cycle k+3.
//  2. dev1 write addr 0x010, di=0x11223344, bank_select=4'b0101 -> RAM[0x10] lanes 0,2 updated; do_ack=2'b10 in cycle k+2.
//  3. Both en same cycle from reset -> dev0 served first, then dev1. Repeat with both held -> grants alternate 0,1,0,1.
//  4. dev0 burst, BURST_LEN=4, addr 0x3FE, en held -> four acks for 0x3FE,0x3FF,0x000,0x001, then IDLE.
//  5. reset asserted during WAIT -> outputs zero immediately, no ack; en still high after release -> full access repeats.
//  6. dev1 burst with en dropped after 2nd ack -> exactly 2 beats, FSM returns to IDLE, dev0 pending request is served next.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Device-side memory request bus shared by fetch (dev0) and decode (dev1).
// The requesters drive the master modport, the arbiter sits on the slave modport.
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [AW-1:0] device_1_mem_addr;
  logic [DW-1:0] device_1_mem_di;
  logic [AW-1:0] device_2_mem_addr;
  logic [DW-1:0] device_2_mem_di;
  logic [3:0]    device_2_bank_select;
  logic [1:0]    devices_burst_en;
  logic [1:0]    devices_mem_we;
  logic [1:0]    devices_mem_en;
  logic [1:0]    devices_do_ack;
  logic [DW-1:0] mem_do;

  modport master (
    output device_1_mem_addr, device_1_mem_di,
    output device_2_mem_addr, device_2_mem_di, device_2_bank_select,
    output devices_burst_en, devices_mem_we, devices_mem_en,
    input  devices_do_ack, mem_do
  );

  modport slave (
    input  device_1_mem_addr, device_1_mem_di,
    input  device_2_mem_addr, device_2_mem_di, device_2_bank_select,
    input  devices_burst_en, devices_mem_we, devices_mem_en,
    output devices_do_ack, mem_do
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting fetch (dev0, read-only) and decode (dev1, byte-lane
// writes) share one synchronous single-port RAM, with optional incrementing bursts.
//
//  state | meaning
//  IDLE  | no access; arbitrate and latch the winner's request
//  ISSUE | RAM strobe for the current beat
//  WAIT  | read data returning from RAM, captured into mem_do
//  ACK   | one-cycle do_ack to the granted device; continue burst or go idle
module mem_arbiter #(
  parameter int AW        = 10,
  parameter int DW        = 32,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output logic          ram_en,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t        state, state_nxt;
  logic          grant, last_grant, pick, burst_go;
  logic          we_q, burst_q;
  logic [BW-1:0] beat;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] di_q, mem_do_q;
  logic [3:0]    be_q;
  logic [1:0]    en;

  // Fetch never writes: its data input and write bit have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{bus.device_1_mem_di, bus.devices_mem_we[0]};

  assign en         = bus.devices_mem_en;
  assign bus.mem_do = mem_do_q;

  // On a tie the device that was not served last wins.
  always_comb begin
    pick     = (en == 2'b11) ? ~last_grant : en[1];
    burst_go = burst_q && (int'(beat) < BURST_LEN - 1) && en[grant];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|en) state_nxt = ISSUE;
      ISSUE:   state_nxt = we_q ? ACK : WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = burst_go ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_en             = 1'b0;
    ram_we             = 1'b0;
    ram_be             = 4'h0;
    ram_addr           = '0;
    ram_di             = '0;
    bus.devices_do_ack = 2'b00;
    if (state == ISSUE) begin
      ram_en   = 1'b1;
      ram_we   = we_q;
      ram_be   = we_q ? be_q : 4'hF;
      ram_addr = addr_q;
      ram_di   = di_q;
    end
    if (state == ACK) bus.devices_do_ack = grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      di_q       <= '0;
      be_q       <= 4'h0;
      burst_q    <= 1'b0;
      mem_do_q   <= '0;
    end else begin
      unique case (state)
        IDLE: if (|en) begin
          grant   <= pick;
          addr_q  <= pick ? bus.device_2_mem_addr : bus.device_1_mem_addr;
          we_q    <= pick & bus.devices_mem_we[1];
          di_q    <= pick ? bus.device_2_mem_di : '0;
          be_q    <= bus.device_2_bank_select;
          burst_q <= bus.devices_burst_en[pick];
          beat    <= '0;
        end
        WAIT: mem_do_q <= ram_do;
        ACK: begin
          last_grant <= grant;
          if (burst_go) begin
            beat   <= beat + 1'b1;
            addr_q <= addr_q + 1'b1;
            if (grant) begin
              di_q <= bus.device_2_mem_di;
              be_q <= bus.device_2_bank_select;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-lane RAM model behind the DUT and a
// reference memory image updated from the access rules predicts every ack and read.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  logic          ram_en, ram_we;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di, ram_do;

  mem_arbiter #(.AW(AW), .DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  // RAM model with a preload port so the array has a single writer.
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_en) begin
      ram_do <= ram[ram_addr];
      if (ram_we)
        for (int i = 0; i < 4; i++)
          if (ram_be[i]) ram[ram_addr][8*i +: 8] <= ram_di[8*i +: 8];
    end
  end

  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] last_rd;
  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic idle_bus();
    bus.device_1_mem_addr = '0; bus.device_1_mem_di = '0;
    bus.device_2_mem_addr = '0; bus.device_2_mem_di = '0;
    bus.device_2_bank_select = 4'h0;
    bus.devices_burst_en = 2'b00; bus.devices_mem_we = 2'b00; bus.devices_mem_en = 2'b00;
  endtask

  // Waits (from a negedge) for the next ack; n = posedges elapsed, -1 on timeout.
  task automatic wait_ack(output logic [1:0] ack, output logic [DW-1:0] data, output int n);
    ack = 2'b00; data = '0; n = 0;
    while (n < 40 && ack == 2'b00) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (bus.devices_do_ack != 2'b00) begin ack = bus.devices_do_ack; data = bus.mem_do; end
    end
    if (ack == 2'b00) n = -1;
  endtask

  // One complete single access starting from IDLE; captures the RAM strobe one cycle in.
  task automatic do_access(input int d, input logic [AW-1:0] a, input logic we,
                           input logic [DW-1:0] di, input logic [3:0] bs,
                           output logic [1:0] ack, output logic [DW-1:0] data, output int n,
                           output logic f_en, output logic f_we, output logic [3:0] f_be,
                           output logic [AW-1:0] f_addr, output logic [DW-1:0] f_di);
    if (d == 0) begin bus.device_1_mem_addr = a; bus.device_1_mem_di = di; end
    else begin bus.device_2_mem_addr = a; bus.device_2_mem_di = di; bus.device_2_bank_select = bs; end
    bus.devices_mem_we[d] = we;
    bus.devices_mem_en[d] = 1'b1;
    ack = 2'b00; data = '0; n = 0;
    f_en = 1'b0; f_we = 1'b0; f_be = 4'h0; f_addr = '0; f_di = '0;
    while (n < 40 && ack == 2'b00) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 1) begin f_en = ram_en; f_we = ram_we; f_be = ram_be; f_addr = ram_addr; f_di = ram_di; end
      if (bus.devices_do_ack != 2'b00) begin ack = bus.devices_do_ack; data = bus.mem_do; end
    end
    if (ack == 2'b00) n = -1;
    bus.devices_mem_en[d] = 1'b0;
    bus.devices_mem_we[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.devices_do_ack !== 2'b00) begin errors++; $display("FAIL reset_ack got=%b exp=00", bus.devices_do_ack); end
    checks++; if (bus.mem_do !== '0) begin errors++; $display("FAIL reset_mem_do got=%h exp=0", bus.mem_do); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_en_we got=%b%b exp=00", ram_en, ram_we); end
    checks++; if (ram_be !== 4'h0) begin errors++; $display("FAIL reset_ram_be got=%h exp=0", ram_be); end
    checks++; if (ram_addr !== '0 || ram_di !== '0) begin errors++; $display("FAIL reset_ram_addr_di got=%h/%h exp=0/0", ram_addr, ram_di); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, bus.devices_do_ack} !== 3'b000) begin
        errors++; $display("FAIL idle_quiet cycle=%0d got en=%b ack=%b exp 0/00", i, ram_en, bus.devices_do_ack);
      end
    end
  endtask

  task automatic test_read();
    logic [1:0] ack; logic [DW-1:0] data, f_di; int n;
    logic f_en, f_we; logic [3:0] f_be; logic [AW-1:0] f_addr;
    preload(10'h005, 32'hDEADBEEF);
    // dev0 with its (ignored) write bit set must still read.
    do_access(0, 10'h005, 1'b1, 32'hFFFF_FFFF, 4'h0, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    checks++; if ({f_en, f_we, f_be, f_addr} !== {1'b1, 1'b0, 4'hF, 10'h005}) begin
      errors++; $display("FAIL read_strobe got en=%b we=%b be=%h addr=%h exp 1/0/f/005", f_en, f_we, f_be, f_addr); end
    checks++; if (ack !== 2'b01 || n != 3) begin errors++; $display("FAIL read_ack got=%b lat=%0d exp=01 lat=3", ack, n); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got=%h exp=deadbeef", data); end
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_write();
    logic [1:0] ack; logic [DW-1:0] data, f_di; int n;
    logic f_en, f_we; logic [3:0] f_be; logic [AW-1:0] f_addr;
    preload(10'h010, 32'hAABBCCDD);
    do_access(1, 10'h010, 1'b1, 32'h11223344, 4'b0101, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    ref_mem[10'h010] = merge(ref_mem[10'h010], 32'h11223344, 4'b0101);
    checks++; if ({f_en, f_we, f_be, f_addr, f_di} !== {1'b1, 1'b1, 4'b0101, 10'h010, 32'h11223344}) begin
      errors++; $display("FAIL write_strobe got en=%b we=%b be=%b addr=%h di=%h", f_en, f_we, f_be, f_addr, f_di); end
    checks++; if (ack !== 2'b10 || n != 2) begin errors++; $display("FAIL write_ack got=%b lat=%0d exp=10 lat=2", ack, n); end
    checks++; if (data !== last_rd) begin errors++; $display("FAIL write_keeps_mem_do got=%h exp=%h", data, last_rd); end
    // Zero byte lanes: still strobed and acked, memory untouched.
    do_access(1, 10'h010, 1'b1, $urandom, 4'b0000, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    checks++; if (ack !== 2'b10 || n != 2 || f_en !== 1'b1 || f_be !== 4'h0) begin
      errors++; $display("FAIL write_be0 got ack=%b lat=%0d en=%b be=%h exp 10/2/1/0", ack, n, f_en, f_be); end
    do_access(0, 10'h010, 1'b0, '0, 4'h0, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    checks++; if (data !== 32'hAA22CC44) begin errors++; $display("FAIL write_readback got=%h exp=aa22cc44", data); end
    last_rd = 32'hAA22CC44;
  endtask

  task automatic test_random();
    logic [1:0] ack; logic [DW-1:0] data, f_di, di; int n, d; logic we;
    logic f_en, f_we; logic [3:0] f_be, bs; logic [AW-1:0] f_addr, a;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 1); a = AW'($urandom); di = $urandom; bs = 4'($urandom);
      we = (d == 1) && ($urandom_range(0, 1) == 1);
      do_access(d, a, we, di, bs, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
      checks++;
      if (we) begin
        ref_mem[a] = merge(ref_mem[a], di, bs);
        if (ack !== 2'b10 || n != 2 || f_addr !== a) begin
          errors++; $display("FAIL rand_write i=%0d got ack=%b lat=%0d addr=%h exp 10/2/%h", i, ack, n, f_addr, a); end
      end else begin
        if (ack !== 2'(1 << d) || n != 3 || data !== ref_mem[a]) begin
          errors++; $display("FAIL rand_read i=%0d dev=%0d got ack=%b lat=%0d data=%h exp lat=3 data=%h", i, d, ack, n, data, ref_mem[a]); end
      end
    end
  endtask

  task automatic test_tie();
    logic [1:0] ack; logic [DW-1:0] data; int n;
    logic [AW-1:0] a0, a1;
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    a0 = AW'($urandom); a1 = AW'($urandom);
    bus.device_1_mem_addr = a0; bus.device_2_mem_addr = a1; bus.devices_mem_en = 2'b11;
    wait_ack(ack, data, n);
    bus.devices_mem_en[0] = 1'b0;
    checks++; if (ack !== 2'b01 || data !== ref_mem[a0]) begin errors++; $display("FAIL tie_first got=%b data=%h exp=01 data=%h", ack, data, ref_mem[a0]); end
    wait_ack(ack, data, n);
    bus.devices_mem_en[1] = 1'b0;
    checks++; if (ack !== 2'b10 || data !== ref_mem[a1]) begin errors++; $display("FAIL tie_second got=%b data=%h exp=10 data=%h", ack, data, ref_mem[a1]); end
    @(negedge clk);
    bus.devices_mem_en = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(ack, data, n);
      checks++;
      if (i % 2 == 0) begin
        if (ack !== 2'b01 || data !== ref_mem[bus.device_1_mem_addr]) begin
          errors++; $display("FAIL tie_alt i=%0d got=%b data=%h exp=01 data=%h", i, ack, data, ref_mem[bus.device_1_mem_addr]); end
        bus.device_1_mem_addr = AW'($urandom);
      end else begin
        if (ack !== 2'b10 || data !== ref_mem[bus.device_2_mem_addr]) begin
          errors++; $display("FAIL tie_alt i=%0d got=%b data=%h exp=10 data=%h", i, ack, data, ref_mem[bus.device_2_mem_addr]); end
        bus.device_2_mem_addr = AW'($urandom);
      end
    end
    bus.devices_mem_en = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [1:0] ack; logic [DW-1:0] data; int n, bad;
    logic [AW-1:0] a;
    bus.device_1_mem_addr = 10'h3FE; bus.devices_burst_en = 2'b01; bus.devices_mem_en = 2'b01;
    for (int b = 0; b < BL; b++) begin
      wait_ack(ack, data, n);
      a = 10'h3FE + AW'(b);
      checks++;
      if (ack !== 2'b01 || n != 3 || data !== ref_mem[a]) begin
        errors++; $display("FAIL burst_beat b=%0d got ack=%b lat=%0d data=%h exp 01/3/%h", b, ack, n, data, ref_mem[a]); end
    end
    // en still high after the last beat: must go idle, not issue a fifth beat.
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL burst_limit got ram_en=%b exp=0", ram_en); end
    bus.devices_mem_en = 2'b00; bus.devices_burst_en = 2'b00;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ram_en !== 1'b0 || bus.devices_do_ack !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL burst_idle got %0d busy cycles exp 0", bad); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ack; logic [DW-1:0] data; int n, bad;
    logic [AW-1:0] a;
    a = AW'($urandom);
    preload(a, 32'h5A5A_0000 | DW'($urandom_range(1, 16'hFFFF)));
    bus.device_1_mem_addr = a; bus.devices_mem_en = 2'b01;
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({ram_en, bus.devices_do_ack, bus.mem_do, ram_addr} !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got en=%b ack=%b mem_do=%h addr=%h exp all 0", ram_en, bus.devices_do_ack, bus.mem_do, ram_addr); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.devices_do_ack !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL reset_mid_no_ack got %0d acks exp 0", bad); end
    reset = 1'b0;
    wait_ack(ack, data, n);
    bus.devices_mem_en = 2'b00;
    checks++; if (ack !== 2'b01 || n != 3 || data !== ref_mem[a]) begin
      errors++; $display("FAIL reset_mid_retry got ack=%b lat=%0d data=%h exp 01/3/%h", ack, n, data, ref_mem[a]); end
    @(negedge clk);
  endtask

  task automatic test_burst_drop();
    logic [1:0] ack; logic [DW-1:0] data, f_di, r0, r1; int n;
    logic f_en, f_we; logic [3:0] f_be, be0, be1; logic [AW-1:0] f_addr, a;
    a = AW'($urandom); r0 = $urandom; r1 = $urandom; be0 = 4'($urandom); be1 = 4'($urandom_range(1, 15));
    bus.device_2_mem_addr = a; bus.device_2_mem_di = r0; bus.device_2_bank_select = be0;
    bus.devices_mem_we = 2'b10; bus.devices_burst_en = 2'b10; bus.devices_mem_en = 2'b10;
    @(negedge clk);
    bus.device_1_mem_addr = a + 1'b1; bus.devices_mem_en[0] = 1'b1;
    wait_ack(ack, data, n);
    ref_mem[a] = merge(ref_mem[a], r0, be0);
    checks++; if (ack !== 2'b10 || n != 1) begin errors++; $display("FAIL bdrop_beat1 got ack=%b n=%0d exp 10/1", ack, n); end
    bus.device_2_mem_di = r1; bus.device_2_bank_select = be1;
    wait_ack(ack, data, n);
    ref_mem[a + 1'b1] = merge(ref_mem[a + 1'b1], r1, be1);
    checks++; if (ack !== 2'b10 || n != 2) begin errors++; $display("FAIL bdrop_beat2 got ack=%b n=%0d exp 10/2", ack, n); end
    bus.devices_mem_en[1] = 1'b0; bus.devices_mem_we = 2'b00; bus.devices_burst_en = 2'b00;
    wait_ack(ack, data, n);
    bus.devices_mem_en[0] = 1'b0;
    checks++; if (ack !== 2'b01 || n != 4 || data !== ref_mem[a + 1'b1]) begin
      errors++; $display("FAIL bdrop_dev0_next got ack=%b n=%0d data=%h exp 01/4/%h", ack, n, data, ref_mem[a + 1'b1]); end
    @(negedge clk);
    do_access(0, a, 1'b0, '0, 4'h0, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    checks++; if (data !== ref_mem[a]) begin errors++; $display("FAIL bdrop_beat1_data got=%h exp=%h", data, ref_mem[a]); end
    do_access(0, a + 2'd2, 1'b0, '0, 4'h0, ack, data, n, f_en, f_we, f_be, f_addr, f_di);
    checks++; if (data !== ref_mem[a + 2'd2]) begin errors++; $display("FAIL bdrop_no_beat3 got=%h exp=%h", data, ref_mem[a + 2'd2]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0; last_rd = '0;
    idle_bus();
    @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) preload(AW'(i), $urandom);
    test_reset();
    test_read();
    test_write();
    test_random();
    test_tie();
    test_burst();
    test_reset_mid();
    test_burst_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
